// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Stage-control bundle helpers keep the per-state output decode readable.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MDU_WAIT = 2'b01,
    HALTED   = 2'b10
  } state_t;

  localparam int unsigned MDU_LAT_DEF = 4;
  localparam int unsigned WCNT_W      = 8;

  typedef struct packed {
    logic en_if;
    logic en_id;
    logic en_ex;
    logic en_mm;
    logic flush_id;
    logic bub_ex;
    logic bub_mm;
  } ctrl_t;

  function automatic ctrl_t ctrl_off();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

  function automatic ctrl_t ctrl_run();
    ctrl_t c;
    c       = '0;
    c.en_if = 1'b1;
    c.en_id = 1'b1;
    c.en_ex = 1'b1;
    c.en_mm = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_branch();
    ctrl_t c;
    c          = ctrl_run();
    c.flush_id = 1'b1;
    c.bub_ex   = 1'b1;
    return c;
  endfunction

  // EX is owned by the MUL/DIV: freeze the front, drain MM/WB behind a bubble.
  function automatic ctrl_t ctrl_mdu();
    ctrl_t c;
    c        = '0;
    c.en_mm  = 1'b1;
    c.bub_mm = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_stall();
    ctrl_t c;
    c        = '0;
    c.en_ex  = 1'b1;
    c.en_mm  = 1'b1;
    c.bub_ex = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/sequencing bundle between the pipeline datapath and pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 8
);

  logic             i_stall;
  logic             i_branch_EX;
  logic             i_mdu_start_EX;
  logic             i_halt_WB;

  logic             o_en_IF;
  logic             o_en_ID;
  logic             o_en_EX;
  logic             o_en_MM;
  logic             o_flush_ID;
  logic             o_bub_EX;
  logic             o_bub_MM;
  logic             o_busy;
  logic             o_halted;
  logic [CNT_W-1:0] o_stall_cycles;

  modport master (
    output i_stall, i_branch_EX, i_mdu_start_EX, i_halt_WB,
    input  o_en_IF, o_en_ID, o_en_EX, o_en_MM,
    input  o_flush_ID, o_bub_EX, o_bub_MM,
    input  o_busy, o_halted, o_stall_cycles
  );

  modport slave (
    input  i_stall, i_branch_EX, i_mdu_start_EX, i_halt_WB,
    output o_en_IF, o_en_ID, o_en_EX, o_en_MM,
    output o_flush_ID, o_bub_EX, o_bub_MM,
    output o_busy, o_halted, o_stall_cycles
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline sequencing controller: load-use stall, taken branch,
// multi-cycle MUL/DIV occupancy of EX and HALT retirement, plus stall counter.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEF,
  parameter int unsigned CNT_W   = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pipeline_ctrl_if.slave bus
);

  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(MDU_LAT - 2);

  state_t              state;
  state_t              state_n;
  logic [WCNT_W-1:0]   wcnt;
  logic [WCNT_W-1:0]   wcnt_n;
  ctrl_t               ctrl;
  logic                inc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    ctrl    = ctrl_off();
    state_n = state;
    wcnt_n  = wcnt;
    if (!i_rst) begin
      unique case (state)
        RUN: begin
          if (bus.i_halt_WB) begin
            ctrl    = ctrl_off();
            state_n = HALTED;
          end else if (bus.i_branch_EX) begin
            ctrl = ctrl_branch();
          end else if (bus.i_mdu_start_EX) begin
            ctrl    = ctrl_mdu();
            wcnt_n  = WCNT_LOAD;
            state_n = MDU_WAIT;
          end else if (bus.i_stall) begin
            ctrl = ctrl_stall();
          end else begin
            ctrl = ctrl_run();
          end
        end
        MDU_WAIT: begin
          if (bus.i_halt_WB) begin
            ctrl    = ctrl_off();
            state_n = HALTED;
          end else if (wcnt != '0) begin
            ctrl   = ctrl_mdu();
            wcnt_n = wcnt - 1'b1;
          end else begin
            // Release: a still-high mdu_start belongs to the leaving op, so no re-entry.
            ctrl    = bus.i_stall ? ctrl_stall() : ctrl_run();
            state_n = RUN;
          end
        end
        HALTED: begin
          ctrl    = ctrl_off();
          state_n = HALTED;
        end
        default: begin
          ctrl    = ctrl_off();
          state_n = RUN;
        end
      endcase
    end
  end

  // The halt cycle itself already targets HALTED, so it is excluded like HALTED.
  assign inc = !i_rst && !ctrl.en_if && (state_n != HALTED) && (state != HALTED);

  assign bus.o_en_IF    = ctrl.en_if;
  assign bus.o_en_ID    = ctrl.en_id;
  assign bus.o_en_EX    = ctrl.en_ex;
  assign bus.o_en_MM    = ctrl.en_mm;
  assign bus.o_flush_ID = ctrl.flush_id;
  assign bus.o_bub_EX   = ctrl.bub_ex;
  assign bus.o_bub_MM   = ctrl.bub_mm;
  assign bus.o_busy     = (state == MDU_WAIT);
  assign bus.o_halted   = (state == HALTED);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (inc),
    .o_cnt (bus.o_stall_cycles)
  );

endmodule
